// File: rtl/cache_wb_controller_if.sv
// CPU-side and memory-side signals of the write-back data cache controller.
// The cache itself uses the slave modport; the pipeline/memory environment uses master.
interface cache_wb_controller_if;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_read;
  logic        cpu_write;
  logic [2:0]  cpu_mask;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        hit;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output cpu_addr, cpu_wdata, cpu_read, cpu_write, cpu_mask, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_stall, hit, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_read, cpu_write, cpu_mask, mem_rdata, mem_ack,
    output cpu_rdata, cpu_stall, hit, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_wb_controller.sv
// Direct-mapped write-back, write-allocate data cache with multi-word lines.
// Hits are served combinationally; misses stall while the FSM writes back a dirty victim and refills.
module cache_wb_controller #(
  parameter int NUM_LINES      = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  cache_wb_controller_if.slave  bus
);
  localparam int OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = 30 - IDX_W - OFF_W;
  localparam int BEAT_W = (OFF_W > 0) ? OFF_W : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(WORDS_PER_LINE - 1);
  localparam logic [BEAT_W-1:0] FIRST_BEAT = '0;

  typedef enum logic [1:0] {IDLE, WB, FILL} state_t;

  state_t              state;
  logic [BEAT_W-1:0]   beat;
  logic [BEAT_W-1:0]   beat_nxt;
  logic [IDX_W-1:0]    req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic [NUM_LINES-1:0] valid;
  logic [NUM_LINES-1:0] dirty;
  logic [TAG_W-1:0]    tag_mem  [NUM_LINES];
  logic [31:0]         data_mem [NUM_LINES][WORDS_PER_LINE];

  logic                mem_req_q;
  logic                mem_we_q;
  logic [31:0]         mem_addr_q;
  logic [31:0]         mem_wdata_q;

  logic [BEAT_W-1:0]   cur_off;
  logic [IDX_W-1:0]    cur_idx;
  logic [TAG_W-1:0]    cur_tag;
  logic                legal;
  logic                active;
  logic                is_load;
  logic                hit_int;
  logic                store_hit;
  logic                beat_done;
  logic                last_beat;
  logic                fill_write;
  logic [31:0]         cur_word;
  logic [7:0]          sel_byte;
  logic [15:0]         sel_half;
  logic [31:0]         load_val;
  logic [3:0]          byte_en;
  logic [31:0]         store_data;
  logic [31:0]         merged;

  function automatic logic [31:0] beat_addr(input logic [TAG_W-1:0]  t,
                                            input logic [IDX_W-1:0]  i,
                                            input logic [BEAT_W-1:0] b);
    return {t, i, {(OFF_W + 2){1'b0}}} | (32'(b) << 2);
  endfunction

  assign cur_off = BEAT_W'(bus.cpu_addr[31:2]) & LAST_BEAT;
  assign cur_idx = bus.cpu_addr[OFF_W+IDX_W+1:OFF_W+2];
  assign cur_tag = bus.cpu_addr[31:OFF_W+IDX_W+2];

  // Byte/half/word loads may be signed or unsigned; stores have no unsigned variants.
  always_comb begin
    legal = 1'b0;
    case (bus.cpu_mask)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = ~bus.cpu_write;
      default:                legal = 1'b0;
    endcase
  end

  assign active    = (bus.cpu_read | bus.cpu_write) & legal;
  assign is_load   = bus.cpu_read & ~bus.cpu_write;
  assign hit_int   = (state == IDLE) & active & valid[cur_idx] & (tag_mem[cur_idx] == cur_tag);
  assign store_hit = hit_int & bus.cpu_write;
  assign cur_word  = data_mem[cur_idx][cur_off];

  always_comb begin
    case (bus.cpu_addr[1:0])
      2'd0:    sel_byte = cur_word[7:0];
      2'd1:    sel_byte = cur_word[15:8];
      2'd2:    sel_byte = cur_word[23:16];
      default: sel_byte = cur_word[31:24];
    endcase
    sel_half = bus.cpu_addr[1] ? cur_word[31:16] : cur_word[15:0];
    case (bus.cpu_mask)
      3'b000:  load_val = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  load_val = {{16{sel_half[15]}}, sel_half};
      3'b100:  load_val = {24'd0, sel_byte};
      3'b101:  load_val = {16'd0, sel_half};
      default: load_val = cur_word;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    case (bus.cpu_mask[1:0])
      2'b00: begin
        byte_en    = 4'b0001 << bus.cpu_addr[1:0];
        store_data = {4{bus.cpu_wdata[7:0]}};
      end
      2'b01: begin
        byte_en    = bus.cpu_addr[1] ? 4'b1100 : 4'b0011;
        store_data = {2{bus.cpu_wdata[15:0]}};
      end
      default: begin
        byte_en    = 4'b1111;
        store_data = bus.cpu_wdata;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = byte_en[i] ? store_data[8*i +: 8] : cur_word[8*i +: 8];
    end
  end

  assign bus.hit       = hit_int;
  assign bus.cpu_stall = (state != IDLE) | (active & ~hit_int);
  assign bus.cpu_rdata = (hit_int & is_load) ? load_val : 32'd0;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  assign beat_done  = mem_req_q & bus.mem_ack;
  assign last_beat  = (beat == LAST_BEAT);
  assign beat_nxt   = beat + 1'b1;
  assign fill_write = (state == FILL) & beat_done;

  // Beat address/data are registered one beat ahead so they hold steady until each ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      beat        <= '0;
      valid       <= '0;
      dirty       <= '0;
      req_idx     <= '0;
      req_tag     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (store_hit) begin
            dirty[cur_idx] <= 1'b1;
          end
          if (active & ~hit_int) begin
            req_idx   <= cur_idx;
            req_tag   <= cur_tag;
            beat      <= '0;
            mem_req_q <= 1'b1;
            if (valid[cur_idx] & dirty[cur_idx]) begin
              state       <= WB;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= beat_addr(tag_mem[cur_idx], cur_idx, FIRST_BEAT);
              mem_wdata_q <= data_mem[cur_idx][FIRST_BEAT];
            end else begin
              state      <= FILL;
              mem_we_q   <= 1'b0;
              mem_addr_q <= beat_addr(cur_tag, cur_idx, FIRST_BEAT);
            end
          end
        end
        WB: begin
          if (beat_done) begin
            if (last_beat) begin
              dirty[req_idx] <= 1'b0;
              state          <= FILL;
              beat           <= '0;
              mem_we_q       <= 1'b0;
              mem_addr_q     <= beat_addr(req_tag, req_idx, FIRST_BEAT);
            end else begin
              beat        <= beat_nxt;
              mem_addr_q  <= beat_addr(tag_mem[req_idx], req_idx, beat_nxt);
              mem_wdata_q <= data_mem[req_idx][beat_nxt];
            end
          end
        end
        FILL: begin
          if (beat_done) begin
            if (last_beat) begin
              valid[req_idx] <= 1'b1;
              dirty[req_idx] <= 1'b0;
              state          <= IDLE;
              beat           <= '0;
              mem_req_q      <= 1'b0;
            end else begin
              beat       <= beat_nxt;
              mem_addr_q <= beat_addr(req_tag, req_idx, beat_nxt);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data and tag arrays carry no reset; valid bits decide whether their contents count.
  always_ff @(posedge clk) begin
    if (store_hit) begin
      data_mem[cur_idx][cur_off] <= merged;
    end
    if (fill_write) begin
      data_mem[req_idx][beat] <= bus.mem_rdata;
      if (last_beat) begin
        tag_mem[req_idx] <= req_tag;
      end
    end
  end
endmodule

// File: tb/tb_cache_wb_controller.sv
// Self-checking bench for cache_wb_controller: a line-level cache/memory model predicts
// stall length, beat traffic and load results; a per-cycle process compares the DUT to it.
module tb_cache_wb_controller;
  localparam int NL         = 64;
  localparam int WPL        = 4;
  localparam int LINE_BYTES = 4 * WPL;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  cache_wb_controller_if bus ();

  cache_wb_controller #(.NUM_LINES(NL), .WORDS_PER_LINE(WPL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] phys_mem [bit [31:0]];
  logic [31:0] ref_mem  [bit [31:0]];
  beat_t       beat_log [$];
  int          ack_delay = 0;
  int          wait_cnt  = 0;

  logic        m_valid [NL];
  logic        m_dirty [NL];
  int unsigned m_tag   [NL];
  logic [31:0] m_data  [NL][WPL];

  logic        chk_en    = 1'b0;
  logic        exp_stall = 1'b0;
  logic        exp_hit   = 1'b0;
  logic [31:0] exp_rdata = '0;
  int          stall_seen = 0;

  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic        prev_we  = 1'b0;
  logic [31:0] prev_addr  = '0;
  logic [31:0] prev_wdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] phys_rd(input logic [31:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  task automatic set_mem(input logic [31:0] a, input logic [31:0] d);
    phys_mem[a] = d;
    ref_mem[a]  = d;
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] a,
                                             input logic [2:0] m);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (m)
      3'b000:  return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      3'b001:  return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] w, input logic [31:0] a,
                                              input logic [31:0] d, input logic [2:0] m);
    logic [31:0] sh;
    case (m)
      3'b000: begin
        sh = 8 * (a % 4);
        return (w & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
      end
      3'b001: begin
        sh = 16 * ((a / 2) % 2);
        return (w & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
      end
      default: return d;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  // Memory responder: acks each beat after ack_delay idle cycles and logs it.
  always @(negedge clk) begin
    if (bus.mem_req && !reset) begin
      if (wait_cnt >= ack_delay) begin
        bus.mem_ack = 1'b1;
        wait_cnt    = 0;
        beat_log.push_back('{bus.mem_we, bus.mem_addr, bus.mem_wdata});
        if (bus.mem_we) phys_mem[bus.mem_addr] = bus.mem_wdata;
        else            bus.mem_rdata = phys_rd(bus.mem_addr);
      end else begin
        bus.mem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      bus.mem_ack = 1'b0;
      wait_cnt    = 0;
    end
  end

  // Per-cycle comparison against the model's expectations plus beat-hold checks.
  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      check("cpu_stall", bus.cpu_stall, exp_stall);
      check("hit", bus.hit, exp_hit);
      check("cpu_rdata", bus.cpu_rdata, exp_rdata);
      if (bus.cpu_stall) stall_seen++;
    end
    if (!reset && bus.mem_req && prev_req && !prev_ack) begin
      check("mem_addr_hold", bus.mem_addr, prev_addr);
      check("mem_we_hold", bus.mem_we, prev_we);
      if (bus.mem_we) check("mem_wdata_hold", bus.mem_wdata, prev_wdata);
    end
    prev_req   = bus.mem_req && !reset;
    prev_ack   = bus.mem_ack;
    prev_we    = bus.mem_we;
    prev_addr  = bus.mem_addr;
    prev_wdata = bus.mem_wdata;
  end

  task automatic applyStimulus(input string name, input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [2:0] mask, input int lit_stall,
                               input logic use_lit, input logic [31:0] lit_rdata);
    logic        legal;
    logic        act;
    int          idx;
    int          off;
    int unsigned tag;
    int          n;
    logic [31:0] res;
    logic [31:0] line_base;
    logic [31:0] vbase;
    beat_t       exp_beats [$];

    idx       = int'((addr / LINE_BYTES) % NL);
    off       = int'((addr / 4) % WPL);
    tag       = addr / (LINE_BYTES * NL);
    line_base = addr - (addr % LINE_BYTES);
    if (wr) legal = (mask <= 3'b010);
    else    legal = (mask <= 3'b010) || (mask == 3'b100) || (mask == 3'b101);
    act = (rd || wr) && legal;
    n   = 0;
    res = '0;
    if (act) begin
      if (!(m_valid[idx] && m_tag[idx] == tag)) begin
        n = 1;
        if (m_valid[idx] && m_dirty[idx]) begin
          vbase = (m_tag[idx] * NL + idx) * LINE_BYTES;
          for (int w = 0; w < WPL; w++) begin
            exp_beats.push_back('{1'b1, vbase + 4 * w, m_data[idx][w]});
            ref_mem[vbase + 4 * w] = m_data[idx][w];
            n += ack_delay + 1;
          end
        end
        for (int w = 0; w < WPL; w++) begin
          exp_beats.push_back('{1'b0, line_base + 4 * w, 32'd0});
          m_data[idx][w] = ref_rd(line_base + 4 * w);
          n += ack_delay + 1;
        end
        m_valid[idx] = 1'b1;
        m_dirty[idx] = 1'b0;
        m_tag[idx]   = tag;
      end
      if (wr) begin
        m_data[idx][off] = model_store(m_data[idx][off], addr, wdata, mask);
        m_dirty[idx]     = 1'b1;
      end else begin
        res = model_load(m_data[idx][off], addr, mask);
      end
    end

    beat_log.delete();
    stall_seen = 0;
    @(posedge clk);
    #1;
    bus.cpu_read  = rd;
    bus.cpu_write = wr;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    bus.cpu_mask  = mask;
    exp_stall = (n > 0);
    exp_hit   = act && (n == 0);
    exp_rdata = (n == 0) ? res : 32'd0;
    chk_en    = 1'b1;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      if (k == n) begin
        exp_stall = 1'b0;
        exp_hit   = act;
        exp_rdata = res;
      end
    end
    @(negedge clk);
    #2;
    chk_en = 1'b0;
    checkOutput(name, n, lit_stall, use_lit, lit_rdata, exp_beats);
    @(posedge clk);
    #1;
    bus.cpu_read  = 1'b0;
    bus.cpu_write = 1'b0;
  endtask

  task automatic checkOutput(input string name, input int n, input int lit_stall,
                             input logic use_lit, input logic [31:0] lit_rdata,
                             input beat_t exp_beats [$]);
    int cnt;
    check({name, " stall_cycles"}, stall_seen, n);
    if (lit_stall >= 0) check({name, " stall_literal"}, stall_seen, lit_stall);
    if (use_lit) check({name, " rdata_literal"}, bus.cpu_rdata, lit_rdata);
    check({name, " beat_count"}, beat_log.size(), exp_beats.size());
    cnt = (beat_log.size() < exp_beats.size()) ? beat_log.size() : exp_beats.size();
    for (int i = 0; i < cnt; i++) begin
      check({name, " beat_we"}, beat_log[i].we, exp_beats[i].we);
      check({name, " beat_addr"}, beat_log[i].addr, exp_beats[i].addr);
      if (exp_beats[i].we) check({name, " beat_wdata"}, beat_log[i].data, exp_beats[i].data);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.cpu_read  = 1'b0;
    bus.cpu_write = 1'b0;
    bus.cpu_mask  = 3'b010;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    model_reset();
    for (int i = 0; i < NL; i++) m_tag[i] = 0;

    set_mem(32'h100, 32'h11);
    set_mem(32'h104, 32'h22);
    set_mem(32'h108, 32'h33);
    set_mem(32'h10C, 32'h44);
    set_mem(32'h1100, 32'hA1A1_A1A1);
    set_mem(32'h2000, 32'h0102_0304);
    set_mem(32'h3040, 32'hCAFE_0001);
    set_mem(32'h3044, 32'hCAFE_8002);

    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset mem_req", bus.mem_req, 1'b0);
    check("reset mem_we", bus.mem_we, 1'b0);
    check("reset cpu_stall", bus.cpu_stall, 1'b0);
    check("reset hit", bus.hit, 1'b0);
    check("reset cpu_rdata", bus.cpu_rdata, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    applyStimulus("lw_100",  1'b1, 1'b0, 32'h100, 32'h0, 3'b010, 5, 1'b1, 32'h11);
    applyStimulus("lw_10C",  1'b1, 1'b0, 32'h10C, 32'h0, 3'b010, 0, 1'b1, 32'h44);
    applyStimulus("sw_104",  1'b0, 1'b1, 32'h104, 32'hDEAD_BEEF, 3'b010, 0, 1'b1, 32'h0);
    applyStimulus("lb_107",  1'b1, 1'b0, 32'h107, 32'h0, 3'b000, 0, 1'b1, 32'hFFFF_FFDE);
    applyStimulus("lbu_106", 1'b1, 1'b0, 32'h106, 32'h0, 3'b100, 0, 1'b1, 32'h0000_00AD);
    applyStimulus("lhu_106", 1'b1, 1'b0, 32'h106, 32'h0, 3'b101, 0, 1'b1, 32'h0000_DEAD);
    applyStimulus("lw_1100", 1'b1, 1'b0, 32'h1100, 32'h0, 3'b010, 9, 1'b1, 32'hA1A1_A1A1);
    check("wb mem_100", phys_rd(32'h100), 32'h11);
    check("wb mem_104", phys_rd(32'h104), 32'hDEAD_BEEF);
    applyStimulus("sb_2003", 1'b0, 1'b1, 32'h2003, 32'h7F, 3'b000, 5, 1'b1, 32'h0);
    applyStimulus("lw_2003", 1'b1, 1'b0, 32'h2003, 32'h0, 3'b010, 0, 1'b1, 32'h7F02_0304);
    applyStimulus("lh_2002", 1'b1, 1'b0, 32'h2002, 32'h0, 3'b001, 0, 1'b1, 32'h0000_7F02);

    // Reset lands in the second FILL beat while the ack is still pending.
    ack_delay = 3;
    @(posedge clk);
    #1;
    bus.cpu_read = 1'b1;
    bus.cpu_addr = 32'h3040;
    bus.cpu_mask = 3'b010;
    repeat (6) @(posedge clk);
    #1;
    check("rst_mid mem_req_before", bus.mem_req, 1'b1);
    check("rst_mid mem_addr_before", bus.mem_addr, 32'h3044);
    check("rst_mid mem_we_before", bus.mem_we, 1'b0);
    #1;
    reset        = 1'b1;
    bus.cpu_read = 1'b0;
    #1;
    check("rst_mid mem_req", bus.mem_req, 1'b0);
    check("rst_mid mem_we", bus.mem_we, 1'b0);
    check("rst_mid cpu_stall", bus.cpu_stall, 1'b0);
    check("rst_mid hit", bus.hit, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();

    applyStimulus("lw_3040_refill", 1'b1, 1'b0, 32'h3040, 32'h0, 3'b010, 17, 1'b1, 32'hCAFE_0001);
    applyStimulus("lw_illegal_011", 1'b1, 1'b0, 32'h3040, 32'h0, 3'b011, 0, 1'b1, 32'h0);
    applyStimulus("rw_sh_3046",     1'b1, 1'b1, 32'h3046, 32'h1234, 3'b001, 0, 1'b1, 32'h0);
    applyStimulus("lhu_3046",       1'b1, 1'b0, 32'h3046, 32'h0, 3'b101, 0, 1'b1, 32'h0000_1234);
    applyStimulus("sw_bad_mask",    1'b0, 1'b1, 32'h3044, 32'hFFFF_FFFF, 3'b100, 0, 1'b0, 32'h0);
    applyStimulus("lw_3044",        1'b1, 1'b0, 32'h3044, 32'h0, 3'b010, 0, 1'b1, 32'h1234_8002);
    applyStimulus("lw_3048_offset", 1'b1, 1'b0, 32'h3048, 32'h0, 3'b010, 0, 1'b0, 32'h0);
    applyStimulus("lb_2000_refill", 1'b1, 1'b0, 32'h2000, 32'h0, 3'b000, 17, 1'b1, 32'h0000_0004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
